// File: rtl/sram_bank_param.sv
// Parametrised single-port SRAM bank with byte-masked writes,
// registered read port and a built-in zero-fill clear sequencer.
module sram_bank_param #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W/8-1:0] M,
  input  logic              clr,
  output logic [DATA_W-1:0] Q,
  output logic              q_valid,
  output logic              busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata;
  logic              acc;

  // accesses only reach the array while the sequencer is idle
  assign acc = (state == IDLE) && !CEN;

  // byte-merge new data over the currently stored word
  always_comb begin
    wdata = mem[A];
    for (int i = 0; i < NB; i++) begin
      if (M[i]) wdata[8*i +: 8] = D[8*i +: 8];
    end
  end

  // array write port: zero-fill while clearing, masked write otherwise
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (acc && !WEN) begin
      mem[A] <= wdata;
    end
  end

  // clear sequencer and registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      busy    <= 1'b1;
      Q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (acc && WEN) begin
            Q       <= mem[A];
            q_valid <= 1'b1;
          end
          // the access above still completes in the cycle clr is taken
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule
